// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin I/D arbiter for a single-port word RAM, with read-modify-write for sub-word stores
module ram_port_arbiter #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_rdata,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [3:0]  d_req_be,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WBACK, RESP} state_t;
  state_t state, nxt;
  logic last_d, owner, we_q, acc, gnt_d, a_we, a_err, sub, rsp_set, rsp_who, rsp_er;
  logic [3:0] be_q;
  logic [31:0] wdata_q, a_addr, mask, merged, rsp_rd;
  always_comb begin
    i_req_ready = state == IDLE && i_req_valid && (!d_req_valid || last_d);
    d_req_ready = state == IDLE && d_req_valid && !i_req_ready;
    acc = i_req_ready || d_req_ready;
    gnt_d = d_req_ready;
    a_addr = gnt_d ? d_req_addr : i_req_addr;
    a_we = gnt_d && d_req_we;
    a_err = a_addr[1:0] != 2'b00 || a_addr >= MEM_BYTES;
    mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    merged = (ram_rdata & ~mask) | (wdata_q & mask);
    sub = we_q && be_q != 4'h0 && be_q != 4'hF;
    nxt = state == IDLE ? (acc ? (a_err ? RESP : ACCESS) : IDLE) :
          state == ACCESS ? (sub ? WBACK : RESP) :
          state == WBACK ? RESP : IDLE;
    rsp_set = (acc && a_err) || (state == ACCESS && !sub) || state == WBACK;
    rsp_who = state == IDLE ? gnt_d : owner;
    rsp_rd = state == ACCESS && !we_q ? ram_rdata : '0;
    rsp_er = state == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b1;
      owner <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      i_rsp_valid <= 1'b0;
      i_rsp_rdata <= '0;
      i_rsp_err <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
      d_rsp_err <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      i_rsp_valid <= rsp_set && !rsp_who;
      d_rsp_valid <= rsp_set && rsp_who;
      if (rsp_set && !rsp_who) begin
        i_rsp_rdata <= rsp_rd;
        i_rsp_err <= rsp_er;
      end
      if (rsp_set && rsp_who) begin
        d_rsp_rdata <= rsp_rd;
        d_rsp_err <= rsp_er;
      end
      if (acc) begin
        last_d <= gnt_d;
        owner <= gnt_d;
        we_q <= a_we;
        be_q <= d_req_be;
        wdata_q <= d_req_wdata;
        if (!a_err) begin
          ram_addr <= a_addr;
          ram_we <= a_we && &d_req_be;
          if (a_we && &d_req_be) ram_wdata <= d_req_wdata;
        end
      end
      if (state == ACCESS && sub) begin
        ram_we <= 1'b1;
        ram_wdata <= merged;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a response scoreboard for ram_port_arbiter
module tb_ram_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req_valid = 1'b0, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr = '0, i_rsp_rdata;
  logic d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid, d_rsp_err;
  logic [3:0] d_req_be = '0;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_rdata;
  logic ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, we_data;
  logic [31:0] mem [16384];
  int cyc = 0, asserts = 0, fails = 0, we_cnt = 0, we_cyc = 0, last_acc = 0, w = 0, g = 0;
  typedef struct {bit p; logic [31:0] rd; bit er; int lat; int acc;} exp_t;
  exp_t sb[$];

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_be(d_req_be), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr[15:2]];
  always @(posedge clk) begin
    cyc++;
    if (ram_we) mem[ram_addr[15:2]] = ram_wdata;
  end
  always @(negedge clk) if (ram_we) begin
    we_cnt++;
    we_cyc = cyc;
    we_data = ram_wdata;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_rsp_valid || d_rsp_valid) begin
      if (sb.size() == 0) chk("unexpected_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("rsp_port", 32'(d_rsp_valid), 32'(e.p));
        chk("rsp_other_valid", 32'(e.p ? i_rsp_valid : d_rsp_valid), 32'h0);
        chk("rsp_rdata", e.p ? d_rsp_rdata : i_rsp_rdata, e.rd);
        chk("rsp_err", 32'(e.p ? d_rsp_err : i_rsp_err), 32'(e.er));
        chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic req(input bit p, input bit we, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input bit ee, input int lat);
    int n = 0;
    @(negedge clk);
    if (p) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_be = be; d_req_addr = a; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = a;
    end
    #1;
    while (!(p ? d_req_ready : i_req_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'h0);
    else begin
      sb.push_back('{p, er, ee, lat, cyc + 1});
      last_acc = cyc + 1;
      @(posedge clk);
    end
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'h0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic tie(input int cnt, input logic [31:0] di, input logic [31:0] dd);
    int k = 0, n = 0;
    bit exp_d = 1'b0, who;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_be = 4'h0; d_req_addr = 32'h20;
    while (k < cnt && n < 100) begin
      #1;
      if (i_req_ready || d_req_ready) begin
        who = d_req_ready;
        chk("both_ready", 32'(i_req_ready & d_req_ready), 32'h0);
        chk("grant_order", 32'(who), 32'(exp_d));
        sb.push_back('{who, who ? dd : di, 1'b0, 2, cyc + 1});
        exp_d = !exp_d;
        k++;
      end
      @(negedge clk);
      n++;
    end
    chk("tie_grants", 32'(k), 32'(cnt));
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hCAFEF00D;
    mem[16383] = 32'h5A5A5A5A;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rsp_valid", {30'b0, i_rsp_valid, d_rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", i_rsp_rdata | d_rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    w = we_cnt;
    tie(4, 32'hDEADBEEF, 32'hCAFEF00D);
    drain();
    req(0, 0, 4'h0, 32'h10, 0, 32'hDEADBEEF, 0, 2);
    drain();
    chk("fetch_no_we", 32'(we_cnt), 32'(w));
    req(0, 0, 4'h0, 32'hFFFC, 0, 32'h5A5A5A5A, 0, 2);
    drain();
    w = we_cnt;
    req(1, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0, 2);
    drain();
    chk("full_we_count", 32'(we_cnt), 32'(w + 1));
    chk("full_we_in_access", 32'(we_cyc), 32'(last_acc));
    chk("full_we_data", we_data, 32'h11223344);
    req(1, 0, 4'h0, 32'h20, 0, 32'h11223344, 0, 2);
    drain();
    w = we_cnt;
    req(1, 1, 4'b0010, 32'h20, 32'h0000AB00, 32'h0, 0, 3);
    drain();
    chk("sub_we_count", 32'(we_cnt), 32'(w + 1));
    chk("sub_we_in_wback", 32'(we_cyc), 32'(last_acc + 1));
    chk("sub_we_data", we_data, 32'h1122AB44);
    chk("sub_mem", mem[8], 32'h1122AB44);
    w = we_cnt;
    req(1, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 0, 2);
    drain();
    chk("be0_no_we", 32'(we_cnt), 32'(w));
    chk("be0_mem", mem[8], 32'h1122AB44);
    req(1, 0, 4'h0, 32'h21, 0, 32'h0, 1, 1);
    req(1, 0, 4'h0, 32'h10000, 0, 32'h0, 1, 1);
    req(1, 1, 4'hF, 32'h22, 32'hFFFFFFFF, 32'h0, 1, 1);
    req(0, 0, 4'h0, 32'h12, 0, 32'h0, 1, 1);
    drain();
    chk("err_no_we", 32'(we_cnt), 32'(w));
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'b0010;
    d_req_addr = 32'h20; d_req_wdata = 32'h00005500;
    g = 0;
    #1;
    while (!d_req_ready && g < 20) begin
      @(negedge clk); #1; g++;
    end
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    g = 0;
    while (!ram_we && g < 20) begin
      @(negedge clk); g++;
    end
    chk("wback_reached", 32'(ram_we), 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_we", 32'(ram_we), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_abort_mem", mem[8], 32'h1122AB44);
    chk("rst_abort_rsp", 32'(d_rsp_valid), 32'h0);
    rst_n = 1'b1;
    tie(2, 32'hDEADBEEF, 32'h1122AB44);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
